// File: rtl/sms_gf_pkg.sv
// Shared definitions for the GF(2^N) power engine and its helpers.
//   state_e          : engine FSM state (IDLE / RUN / DONE)
//   GF_DEFAULT_POLY  : x^6 + x + 1, default reduction polynomial for N=6
//   gf_cnt_w(n)      : width of an exponent bit index counter for an n-bit field
package sms_gf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [6:0] GF_DEFAULT_POLY = 7'b1000011;

    // Index counter must hold n-1; never narrower than one bit.
    function automatic int unsigned gf_cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sms_gf_mul.sv
// Combinational GF(2^N) multiplier, polynomial basis.
//   a_i, b_i : operands (N bits)
//   p_o      : a_i * b_i mod POLY (N bits)
// Horner form, MSB of b first: shift-and-reduce, then conditionally add a.
module sms_gf_mul
    import sms_gf_pkg::*;
#(
    parameter int unsigned N    = 6,
    parameter logic [N:0]  POLY = (N+1)'(GF_DEFAULT_POLY)
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] p_o
);

    logic [N-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            // x*acc: drop x^N and fold it back in as the low terms of POLY
            acc = (acc << 1) ^ (acc[N-1] ? POLY[N-1:0] : '0);
            if (b_i[i]) acc = acc ^ a_i;
        end
        p_o = acc;
    end

endmodule

// File: rtl/sms_gf_power_engine.sv
// Sequential y = x^e in GF(2^N), one exponent bit per cycle, MSB first.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (in_x base, in_exp exponent)
//   out_valid/out_ready   : result handshake (out_y = in_x^in_exp)
//   busy                  : engine in RUN or DONE
// Every RUN cycle does one square and one multiply; the multiply operand is
// muxed to 1 for zero exponent bits so timing/activity never depend on data.
module sms_gf_power_engine
    import sms_gf_pkg::*;
#(
    parameter int unsigned N    = 6,
    parameter logic [N:0]  POLY = (N+1)'(GF_DEFAULT_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_exp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         busy
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("sms_gf_power_engine: N must be in 2..16");
    end
    if (POLY[N] != 1'b1) begin : g_bad_poly
        $error("sms_gf_power_engine: POLY[N] must be 1");
    end

    localparam int unsigned   IW  = gf_cnt_w(N);
    localparam logic [N-1:0]  ONE = N'(1);

    state_e        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  exp_q, exp_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  y_q, y_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [N-1:0]  sq;
    logic [N-1:0]  mop;
    logic [N-1:0]  prod;

    sms_gf_mul #(.N(N), .POLY(POLY)) u_sq (
        .a_i (acc_q),
        .b_i (acc_q),
        .p_o (sq)
    );

    assign mop = exp_q[idx_q] ? x_q : ONE;

    sms_gf_mul #(.N(N), .POLY(POLY)) u_mul (
        .a_i (sq),
        .b_i (mop),
        .p_o (prod)
    );

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_y     = y_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        y_d     = y_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    x_d     = in_x;
                    exp_d   = in_exp;
                    acc_d   = ONE;
                    idx_d   = IW'(N - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = prod;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    y_d     = prod;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            exp_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_sms_gf_power_engine.sv
// Self-checking bench: directed cases, exhaustive N=6 sweep, randomized
// backpressure, async reset abort, and an N=4 instance spot set.
module tb_sms_gf_power_engine;

    localparam int         N     = 6;
    localparam logic [6:0] POLY  = 7'b1000011;
    localparam int         N4    = 4;
    localparam logic [4:0] POLY4 = 5'b10011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [N-1:0]  in_x = '0, in_exp = '0, out_y;
    logic          in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
    logic [N4-1:0] in_x4 = '0, in_exp4 = '0, out_y4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sms_gf_power_engine #(.N(N), .POLY(POLY)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
    );

    sms_gf_power_engine #(.N(N4), .POLY(POLY4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_x(in_x4), .in_exp(in_exp4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_y(out_y4), .busy(busy4)
    );

    // Reference: schoolbook carry-less product, long-division reduction,
    // and x^e as e repeated multiplications.
    function automatic int ref_mul(input int a, input int b, input int n, input int poly);
        int p = 0;
        for (int i = 0; i < n; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 2 * n - 2; i >= n; i--) if (((p >> i) & 1) != 0) p = p ^ (poly << (i - n));
        return p;
    endfunction

    function automatic int ref_pow(input int x, input int e, input int n, input int poly);
        int r = 1;
        for (int k = 0; k < e; k++) r = ref_mul(r, x, n, poly);
        return r;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand to the N=6 engine and wait for the result. If
    // out_ready is high the result handshake edge is consumed too; otherwise
    // it returns with the engine sitting in DONE.
    task automatic op6(input int x, input int e, input int expy, input string tag);
        int w = 0;
        while (!in_ready && w < 40) begin step(); w++; end
        check({tag, " in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_x     = N'(x);
        in_exp   = N'(e);
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin step(); w++; end
        check({tag, " latency"}, w, N);
        check({tag, " y"}, int'(out_y), expy);
        if (out_ready) step();
    endtask

    task automatic op4(input int x, input int e, input int expy, input string tag);
        int w = 0;
        while (!in_ready4 && w < 40) begin step(); w++; end
        in_valid4 = 1'b1;
        in_x4     = N4'(x);
        in_exp4   = N4'(e);
        step();
        in_valid4 = 1'b0;
        w = 0;
        while (!out_valid4 && w < 40) begin step(); w++; end
        check({tag, " latency4"}, w, N4);
        check({tag, " y4"}, int'(out_y4), expy);
        step();
    endtask

    initial begin
        int y_hold;
        int bad;

        // Reset state, observed while reset is held (no clock edge needed).
        #2;
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_y", int'(out_y), 0);
        check("rst busy", int'(busy), 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("post-rst in_ready", int'(in_ready), 1);
        check("post-rst busy", int'(busy), 0);

        // Directed values
        op6(8'h02, 13, 8'h0A, "alpha^13");
        op6(8'h02, 62, 8'h21, "alpha^-1");
        op6(8'h02, 63, 8'h01, "alpha^63");
        op6(8'h00, 0,  8'h01, "0^0");
        op6(8'h00, 13, 8'h00, "0^13");
        op6(8'h2A, 1,  8'h2A, "x^1");
        op6(8'h20, 2,  8'h30, "x^5 squared");

        // Backpressure: result and handshakes frozen while out_ready=0.
        out_ready = 1'b0;
        op6(8'h15, 13, ref_pow(8'h15, 13, N, int'(POLY)), "bp");
        y_hold = int'(out_y);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = N'($urandom);
            in_exp   = N'($urandom);
            step();
            check("bp out_valid", int'(out_valid), 1);
            check("bp out_y", int'(out_y), y_hold);
            check("bp in_ready", int'(in_ready), 0);
            check("bp busy", int'(busy), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp release out_valid", int'(out_valid), 0);
        check("bp release in_ready", int'(in_ready), 1);
        check("bp release out_y held", int'(out_y), y_hold);
        op6(8'h02, 13, 8'h0A, "after bp");

        // Async reset mid-RUN (idx=3), no stale result afterwards.
        in_valid = 1'b1;
        in_x     = N'(8'h02);
        in_exp   = N'(13);
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", int'(out_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort in_ready", int'(in_ready), 0);
        step(); step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < N + 3; i++) begin
            step();
            if (out_valid || busy) bad++;
        end
        check("abort no stale result", bad, 0);
        op6(8'h02, 13, 8'h0A, "after abort");

        // Exhaustive N=6 sweep against the reference model.
        for (int x = 0; x < 64; x++)
            for (int e = 0; e < 64; e++)
                op6(x, e, ref_pow(x, e, N, int'(POLY)), "sweep");

        // Random operands with random result backpressure.
        for (int i = 0; i < 30; i++) begin
            int rx, re, hold;
            rx   = int'($urandom_range(0, 63));
            re   = int'($urandom_range(0, 63));
            hold = int'($urandom_range(0, 3));
            out_ready = (hold == 0);
            op6(rx, re, ref_pow(rx, re, N, int'(POLY)), "rand");
            if (hold != 0) begin
                y_hold = int'(out_y);
                repeat (hold) begin
                    step();
                    check("rand hold y", int'(out_y), y_hold);
                    check("rand hold valid", int'(out_valid), 1);
                end
                out_ready = 1'b1;
                step();
                check("rand release", int'(out_valid), 0);
            end
        end
        out_ready = 1'b1;

        // N=4 instance spot set.
        op4(4'h2, 14, 4'h9, "n4 alpha^-1");
        op4(4'h2, 15, 4'h1, "n4 alpha^15");
        op4(4'h0, 0,  4'h1, "n4 0^0");
        op4(4'h0, 5,  4'h0, "n4 0^5");
        for (int i = 0; i < 10; i++) begin
            int rx, re;
            rx = int'($urandom_range(0, 15));
            re = int'($urandom_range(0, 15));
            op4(rx, re, ref_pow(rx, re, N4, int'(POLY4)), "n4 rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
